// File: rtl/rv_pkg.sv
// +----------------------------------------------------------------------+
// | rv_pkg : shared RV32I opcodes, ctrl field widths and ctrl bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int ALUOP_W  = 5;
    localparam int NPCOP_W  = 3;
    localparam int WDSEL_W  = 2;
    localparam int DMTYPE_W = 3;

    typedef struct packed {
        logic                reg_write;
        logic                mem_write;
        logic                mem_read;
        logic                alu_src;
        logic [ALUOP_W-1:0]  alu_op;
        logic [NPCOP_W-1:0]  npc_op;
        logic [WDSEL_W-1:0]  wd_sel;
        logic [DMTYPE_W-1:0] dm_type;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// +----------------------------------------------------------------------+
// | hazard_detect : operand-use decode and load-use hazard compare       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_detect
    import rv_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [6:0] id_op_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    output logic       load_use_o
);

    logic use_rs1;
    logic use_rs2;

    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (id_op_i)
            OP_LUI, OP_AUIPC, OP_JAL: use_rs1 = 1'b0;
            default:                  use_rs1 = 1'b1;
        endcase
        case (id_op_i)
            OP_R, OP_STORE, OP_BRANCH: use_rs2 = 1'b1;
            default:                   use_rs2 = 1'b0;
        endcase
    end

    assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & id_valid_i &
                        ((use_rs1 & (ex_rd_i == id_rs1_i)) |
                         (use_rs2 & (ex_rd_i == id_rs2_i)));

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe.sv
// +----------------------------------------------------------------------+
// | id_ex_pipe : ID/EX register with load-use bubbles, flush, hold and   |
// |              saturating stall/flush event counters                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module id_ex_pipe
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                id_valid,
    input  logic [6:0]          id_op,
    input  logic                id_RegWrite,
    input  logic                id_MemWrite,
    input  logic                id_MemRead,
    input  logic                id_ALUSrc,
    input  logic [ALUOP_W-1:0]  id_ALUOp,
    input  logic [NPCOP_W-1:0]  id_NPCOp,
    input  logic [WDSEL_W-1:0]  id_WDSel,
    input  logic [DMTYPE_W-1:0] id_DMType,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [XLEN-1:0]     id_rd1,
    input  logic [XLEN-1:0]     id_rd2,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic [4:0]          id_rd,
    input  logic                ex_flush,
    input  logic                ex_hold,
    output logic                ex_valid,
    output logic                ex_RegWrite,
    output logic                ex_MemWrite,
    output logic                ex_MemRead,
    output logic                ex_ALUSrc,
    output logic [ALUOP_W-1:0]  ex_ALUOp,
    output logic [NPCOP_W-1:0]  ex_NPCOp,
    output logic [WDSEL_W-1:0]  ex_WDSel,
    output logic [DMTYPE_W-1:0] ex_DMType,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_rd1,
    output logic [XLEN-1:0]     ex_rd2,
    output logic [XLEN-1:0]     ex_imm,
    output logic [4:0]          ex_rs1,
    output logic [4:0]          ex_rs2,
    output logic [4:0]          ex_rd,
    output logic                stall_if_id,
    output logic [CNT_W-1:0]    cnt_loaduse,
    output logic [CNT_W-1:0]    cnt_flush
);

    ctrl_t            id_ctrl;
    ctrl_t            ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d, cnt_fl_q, cnt_fl_d;
    logic             load_use;
    logic             bubble;
    logic             load;

    always_comb begin
        id_ctrl.reg_write = id_RegWrite;
        id_ctrl.mem_write = id_MemWrite;
        id_ctrl.mem_read  = id_MemRead;
        id_ctrl.alu_src   = id_ALUSrc;
        id_ctrl.alu_op    = id_ALUOp;
        id_ctrl.npc_op    = id_NPCOp;
        id_ctrl.wd_sel    = id_WDSel;
        id_ctrl.dm_type   = id_DMType;
    end

    hazard_detect u_hazard_detect (
        .id_valid_i    (id_valid),
        .id_op_i       (id_op),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rd_q),
        .load_use_o    (load_use)
    );

    // Flush outranks hold: the ID instruction is being killed, so IF/ID must not freeze.
    assign stall_if_id = (load_use | ex_hold) & ~ex_flush;
    assign bubble      = ex_flush | (~ex_hold & load_use);
    assign load        = ~ex_flush & ~ex_hold & ~load_use;

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        pc_d     = pc_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        cnt_lu_d = cnt_lu_q;
        cnt_fl_d = cnt_fl_q;
        if (bubble) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            pc_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
        end else if (load) begin
            valid_d = id_valid;
            ctrl_d  = id_ctrl;
            pc_d    = id_pc;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            rs1_d   = id_rs1;
            rs2_d   = id_rs2;
            rd_d    = id_rd;
        end
        if (ex_flush) begin
            if (cnt_fl_q != '1) cnt_fl_d = cnt_fl_q + CNT_W'(1);
        end else if (~ex_hold & load_use) begin
            if (cnt_lu_q != '1) cnt_lu_d = cnt_lu_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            pc_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            cnt_lu_q <= '0;
            cnt_fl_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            cnt_lu_q <= cnt_lu_d;
            cnt_fl_q <= cnt_fl_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_ALUOp    = ctrl_q.alu_op;
    assign ex_NPCOp    = ctrl_q.npc_op;
    assign ex_WDSel    = ctrl_q.wd_sel;
    assign ex_DMType   = ctrl_q.dm_type;
    assign ex_pc       = pc_q;
    assign ex_rd1      = rd1_q;
    assign ex_rd2      = rd2_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign cnt_loaduse = cnt_lu_q;
    assign cnt_flush   = cnt_fl_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
// +----------------------------------------------------------------------+
// | tb_id_ex_pipe : random stimulus against a behavioural EX-slot model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        alu_src;
        logic [4:0]  alu_op;
        logic [2:0]  npc_op;
        logic [1:0]  wd_sel;
        logic [2:0]  dm_type;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } slot_t;

    logic        clk;
    logic        rstn;
    logic        ex_flush, ex_hold;
    slot_t       id_in;
    logic [6:0]  id_op;

    slot_t       d1_out, d2_out;
    logic        d1_stall, d2_stall;
    logic [15:0] d1_cnt_lu, d1_cnt_fl;
    logic [1:0]  d2_cnt_lu, d2_cnt_fl;

    int n_checks = 0;
    int n_fail   = 0;

    slot_t m_ex;
    int    m_lu, m_fl;

    id_ex_pipe #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_in.valid), .id_op(id_op),
        .id_RegWrite(id_in.reg_write), .id_MemWrite(id_in.mem_write),
        .id_MemRead(id_in.mem_read), .id_ALUSrc(id_in.alu_src),
        .id_ALUOp(id_in.alu_op), .id_NPCOp(id_in.npc_op), .id_WDSel(id_in.wd_sel),
        .id_DMType(id_in.dm_type), .id_pc(id_in.pc), .id_rd1(id_in.rd1),
        .id_rd2(id_in.rd2), .id_imm(id_in.imm), .id_rs1(id_in.rs1),
        .id_rs2(id_in.rs2), .id_rd(id_in.rd), .ex_flush(ex_flush), .ex_hold(ex_hold),
        .ex_valid(d1_out.valid), .ex_RegWrite(d1_out.reg_write),
        .ex_MemWrite(d1_out.mem_write), .ex_MemRead(d1_out.mem_read),
        .ex_ALUSrc(d1_out.alu_src), .ex_ALUOp(d1_out.alu_op), .ex_NPCOp(d1_out.npc_op),
        .ex_WDSel(d1_out.wd_sel), .ex_DMType(d1_out.dm_type), .ex_pc(d1_out.pc),
        .ex_rd1(d1_out.rd1), .ex_rd2(d1_out.rd2), .ex_imm(d1_out.imm),
        .ex_rs1(d1_out.rs1), .ex_rs2(d1_out.rs2), .ex_rd(d1_out.rd),
        .stall_if_id(d1_stall), .cnt_loaduse(d1_cnt_lu), .cnt_flush(d1_cnt_fl)
    );

    id_ex_pipe #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .id_valid(id_in.valid), .id_op(id_op),
        .id_RegWrite(id_in.reg_write), .id_MemWrite(id_in.mem_write),
        .id_MemRead(id_in.mem_read), .id_ALUSrc(id_in.alu_src),
        .id_ALUOp(id_in.alu_op), .id_NPCOp(id_in.npc_op), .id_WDSel(id_in.wd_sel),
        .id_DMType(id_in.dm_type), .id_pc(id_in.pc), .id_rd1(id_in.rd1),
        .id_rd2(id_in.rd2), .id_imm(id_in.imm), .id_rs1(id_in.rs1),
        .id_rs2(id_in.rs2), .id_rd(id_in.rd), .ex_flush(ex_flush), .ex_hold(ex_hold),
        .ex_valid(d2_out.valid), .ex_RegWrite(d2_out.reg_write),
        .ex_MemWrite(d2_out.mem_write), .ex_MemRead(d2_out.mem_read),
        .ex_ALUSrc(d2_out.alu_src), .ex_ALUOp(d2_out.alu_op), .ex_NPCOp(d2_out.npc_op),
        .ex_WDSel(d2_out.wd_sel), .ex_DMType(d2_out.dm_type), .ex_pc(d2_out.pc),
        .ex_rd1(d2_out.rd1), .ex_rd2(d2_out.rd2), .ex_imm(d2_out.imm),
        .ex_rs1(d2_out.rs1), .ex_rs2(d2_out.rs2), .ex_rd(d2_out.rd),
        .stall_if_id(d2_stall), .cnt_loaduse(d2_cnt_lu), .cnt_flush(d2_cnt_fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    // A valid load in EX whose destination is read by the valid ID instruction.
    function automatic bit model_hazard();
        if (!(m_ex.valid && m_ex.mem_read && m_ex.rd != 0 && id_in.valid)) return 0;
        return (reads_rs1(id_op) && m_ex.rd == id_in.rs1) ||
               (reads_rs2(id_op) && m_ex.rd == id_in.rs2);
    endfunction

    task automatic model_edge();
        bit hz;
        hz = model_hazard();
        if (!rstn) begin
            m_ex = '0; m_lu = 0; m_fl = 0;
        end else if (ex_flush) begin
            m_ex = '0; m_fl++;
        end else if (ex_hold) begin
            m_ex = m_ex;
        end else if (hz) begin
            m_ex = '0; m_lu++;
        end else begin
            m_ex = id_in;
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic randomize_inputs(input int cyc);
        logic [6:0] ops [8];
        int k;
        ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        k = $urandom_range(0, 8);
        id_op           = (k == 8) ? 7'($urandom) : ops[k];
        id_in.valid     = ($urandom_range(0, 99) < 85);
        id_in.reg_write = 1'($urandom);
        id_in.mem_write = 1'($urandom);
        id_in.mem_read  = ($urandom_range(0, 99) < 45);
        id_in.alu_src   = 1'($urandom);
        id_in.alu_op    = 5'($urandom);
        id_in.npc_op    = 3'($urandom);
        id_in.wd_sel    = 2'($urandom);
        id_in.dm_type   = 3'($urandom);
        id_in.pc        = $urandom;
        id_in.rd1       = $urandom;
        id_in.rd2       = $urandom;
        id_in.imm       = $urandom;
        id_in.rs1       = 5'($urandom_range(0, 3));
        id_in.rs2       = 5'($urandom_range(0, 3));
        id_in.rd        = 5'($urandom_range(0, 3));
        ex_flush        = ($urandom_range(0, 99) < 8);
        ex_hold         = ($urandom_range(0, 99) < 12);
        rstn            = ($urandom_range(0, 199) != 0);
        if (cyc < 2) begin
            rstn = 1'b0; id_in.valid = 1'b1; id_in.reg_write = 1'b1;
        end
        // Directed: lw x5,0(x1) then add x6,x5,x2; held-stage window; flush+hold together.
        if (cyc >= 2 && cyc <= 4) begin
            rstn = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0; id_in.valid = 1'b1;
        end
        if (cyc == 2) begin
            id_op = 7'b0000011; id_in.mem_read = 1'b1; id_in.rd = 5'd5; id_in.rs1 = 5'd1;
        end
        if (cyc == 3 || cyc == 4) begin
            id_op = 7'b0110011; id_in.mem_read = 1'b0; id_in.pc = 32'h10;
            id_in.rd = 5'd6; id_in.rs1 = 5'd5; id_in.rs2 = 5'd2;
            id_in.rd1 = 32'd5; id_in.rd2 = 32'd7;
        end
        if (cyc >= 6 && cyc <= 8) begin
            rstn = 1'b1; ex_flush = 1'b0; ex_hold = 1'b1;
        end
        if (cyc == 9) begin
            rstn = 1'b1; ex_flush = 1'b1; ex_hold = 1'b1;
        end
    endtask

    initial begin
        m_ex = '0; m_lu = 0; m_fl = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            randomize_inputs(cyc);
            #1;
            if (cyc > 0) begin
                check("stall", 256'(d1_stall), 256'((model_hazard() | ex_hold) & ~ex_flush));
                check("stall_sat", 256'(d2_stall), 256'(d1_stall));
            end
            @(posedge clk);
            model_edge();
            #1;
            check("ex_bundle", 256'(d1_out), 256'(m_ex));
            check("ex_bundle_sat", 256'(d2_out), 256'(m_ex));
            check("cnt_loaduse", 256'(d1_cnt_lu), 256'(sat(m_lu, 65535)));
            check("cnt_flush", 256'(d1_cnt_fl), 256'(sat(m_fl, 65535)));
            check("cnt_loaduse_sat", 256'(d2_cnt_lu), 256'(sat(m_lu, 3)));
            check("cnt_flush_sat", 256'(d2_cnt_fl), 256'(sat(m_fl, 3)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
